// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SEG_W      = 7;

  // Scan FSM encoding
  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // All-dark levels for the active-low anode and cathode buses
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;
  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_hex7_decode.sv
// Nibble to active-low seven-segment glyph.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup
  always_comb begin
    seg_c = SEG_LUT[nib_i];
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit seven-segment scanner with anti-ghost blanking,
// decimal points and optional leading-zero suppression.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [31:0]           value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lz_blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           shadow_q;
  logic [3:0]            nib_q, nib_c;
  logic                  uz_q, uz_c;
  logic                  wrap_c;
  logic                  slot_start_c;
  logic                  blank_digit_c;
  logic [SEG_W-1:0]      seg_dec_c;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q;

  // Prescaler and SHOW/BLANK sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    wrap_c  = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          wrap_c  = (idx_q == IDX_W'(NUM_DIGITS - 1));
        end
      end
    endcase
  end

  // Freeze the digit's nibble and zero-suffix flag at slot start so a load
  // mid-slot only shows up from the next digit onward
  always_comb begin
    slot_start_c = (state_q == ST_SHOW) && (cnt_q == '0);
    nib_c        = nib_q;
    uz_c         = uz_q;
    if (slot_start_c) begin
      nib_c = shadow_q[{idx_q, 2'b00} +: 4];
      uz_c  = ((shadow_q >> {idx_q, 2'b00}) == 32'h0);
    end
  end

  hex7_decode u_dec (
    .nib_i (nib_c),
    .seg_c (seg_dec_c)
  );

  // Next output levels; dp_mask and lz_blank are used live
  always_comb begin
    blank_digit_c = lz_blank && (idx_q != '0) && uz_c;
    an_d          = AN_OFF;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    if ((state_q == ST_SHOW) && !blank_digit_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = seg_dec_c;
      dp_d  = ~dp_mask[idx_q];
    end
  end

  // State, shadow and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= ST_SHOW;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= 32'h0;
      nib_q    <= 4'h0;
      uz_q     <= 1'b1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_c;
      uz_q    <= uz_c;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= wrap_c;
      if (load) begin
        shadow_q <= value;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with TICK_DIV=4, BLANK_CYC=2 (48-cycle frame).
module tb_seg7_scan;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic [7:0]  dp_mask;
  logic        lz_blank;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan #(.TICK_DIV(4), .BLANK_CYC(2)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] val;
    logic        lz;
    logic [7:0]  dpm;
    int          digit;
    logic [7:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
  } vec_t;

  localparam int N_VEC = 26;
  vec_t vecs [N_VEC];

  task automatic chk(input string name, input logic [7:0] ae, input logic [6:0] se, input logic de);
    n_vec++;
    if (an !== ae || seg !== se || dp !== de) begin
      n_err++;
      $display("FAIL %s: got an=%h seg=%b dp=%b, want an=%h seg=%b dp=%b", name, an, seg, dp, ae, se, de);
    end
  endtask

  task automatic chk_fd(input string name, input logic fe);
    n_vec++;
    if (frame_done !== fe) begin
      n_err++;
      $display("FAIL %s: got frame_done=%b, want %b", name, frame_done, fe);
    end
  endtask

  // Load a value, then park on the next frame_done sample (digit 0 slot begins)
  task automatic sync_load(input logic [31:0] v, input logic l, input logic [7:0] m);
    bit got;
    value    = v;
    load     = 1'b1;
    lz_blank = l;
    dp_mask  = m;
    @(negedge clk_in);
    load = 1'b0;
    got  = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      if (frame_done === 1'b1) got = 1'b1;
      else @(negedge clk_in);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL sync: got no frame_done within 60 cycles, want a pulse");
    end
  endtask

  initial begin
    vecs[0]  = '{32'h01234567, 1'b0, 8'h00, 0, 8'hFE, 7'b1111000, 1'b1};
    vecs[1]  = '{32'h01234567, 1'b0, 8'h00, 1, 8'hFD, 7'b0000010, 1'b1};
    vecs[2]  = '{32'h01234567, 1'b0, 8'h00, 4, 8'hEF, 7'b0110000, 1'b1};
    vecs[3]  = '{32'h01234567, 1'b0, 8'h00, 7, 8'h7F, 7'b1000000, 1'b1};
    vecs[4]  = '{32'h000000A0, 1'b1, 8'h00, 0, 8'hFE, 7'b1000000, 1'b1};
    vecs[5]  = '{32'h000000A0, 1'b1, 8'h00, 1, 8'hFD, 7'b0001000, 1'b1};
    vecs[6]  = '{32'h000000A0, 1'b1, 8'h00, 2, 8'hFF, 7'h7F,      1'b1};
    vecs[7]  = '{32'h000000A0, 1'b1, 8'h00, 7, 8'hFF, 7'h7F,      1'b1};
    vecs[8]  = '{32'h00000000, 1'b1, 8'h01, 0, 8'hFE, 7'b1000000, 1'b0};
    vecs[9]  = '{32'h00000000, 1'b1, 8'h01, 3, 8'hFF, 7'h7F,      1'b1};
    vecs[10] = '{32'h89ABCDEF, 1'b0, 8'hAA, 0, 8'hFE, 7'b0001110, 1'b1};
    vecs[11] = '{32'h89ABCDEF, 1'b0, 8'hAA, 1, 8'hFD, 7'b0000110, 1'b0};
    vecs[12] = '{32'h89ABCDEF, 1'b0, 8'hAA, 2, 8'hFB, 7'b0100001, 1'b1};
    vecs[13] = '{32'h89ABCDEF, 1'b0, 8'hAA, 3, 8'hF7, 7'b1000110, 1'b0};
    vecs[14] = '{32'h89ABCDEF, 1'b0, 8'hAA, 4, 8'hEF, 7'b0000011, 1'b1};
    vecs[15] = '{32'h89ABCDEF, 1'b0, 8'hAA, 5, 8'hDF, 7'b0001000, 1'b0};
    vecs[16] = '{32'h89ABCDEF, 1'b0, 8'hAA, 6, 8'hBF, 7'b0010000, 1'b1};
    vecs[17] = '{32'h89ABCDEF, 1'b0, 8'hAA, 7, 8'h7F, 7'b0000000, 1'b0};
    vecs[18] = '{32'h00FF0000, 1'b1, 8'hFF, 7, 8'hFF, 7'h7F,      1'b1};
    vecs[19] = '{32'h00FF0000, 1'b1, 8'hFF, 6, 8'hFF, 7'h7F,      1'b1};
    vecs[20] = '{32'h00FF0000, 1'b1, 8'hFF, 5, 8'hDF, 7'b0001110, 1'b0};
    vecs[21] = '{32'h00FF0000, 1'b1, 8'hFF, 1, 8'hFD, 7'b1000000, 1'b0};
    vecs[22] = '{32'h76543210, 1'b0, 8'h00, 1, 8'hFD, 7'b1111001, 1'b1};
    vecs[23] = '{32'h76543210, 1'b0, 8'h00, 2, 8'hFB, 7'b0100100, 1'b1};
    vecs[24] = '{32'h76543210, 1'b0, 8'h00, 4, 8'hEF, 7'b0011001, 1'b1};
    vecs[25] = '{32'h76543210, 1'b0, 8'h00, 5, 8'hDF, 7'b0010010, 1'b1};

    rst      = 1'b1;
    value    = 32'h0;
    load     = 1'b0;
    dp_mask  = 8'h00;
    lz_blank = 1'b0;

    // Reset held three cycles: dark, no frame pulse
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("reset_hold", 8'hFF, 7'h7F, 1'b1);
      chk_fd("reset_fd", 1'b0);
    end
    rst = 1'b0;

    // First digit-0 slot after release lasts a full 4 cycles, then blanks
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (k <= 4) chk("post_reset_d0", 8'hFE, 7'b1000000, 1'b1);
      else        chk("post_reset_blank", 8'hFF, 7'h7F, 1'b1);
    end

    // Table: one slot per vector, plus frame_done cadence
    for (int v = 0; v < N_VEC; v++) begin
      int d;
      int fd_extra;
      d = vecs[v].digit;
      fd_extra = 0;
      sync_load(vecs[v].val, vecs[v].lz, vecs[v].dpm);
      for (int k = 1; k <= 48; k++) begin
        @(negedge clk_in);
        if (k >= 1 + 6 * d && k <= 4 + 6 * d)
          chk($sformatf("vec%0d_show", v), vecs[v].an_e, vecs[v].seg_e, vecs[v].dp_e);
        else if (k == 5 + 6 * d || k == 6 + 6 * d)
          chk($sformatf("vec%0d_blank", v), 8'hFF, 7'h7F, 1'b1);
        if (k < 48 && frame_done !== 1'b0) fd_extra++;
        if (k == 48) chk_fd($sformatf("vec%0d_frame_period", v), 1'b1);
      end
      n_vec++;
      if (fd_extra != 0) begin
        n_err++;
        $display("FAIL vec%0d_fd_extra: got %0d stray frame_done cycles, want 0", v, fd_extra);
      end
    end

    // Load mid-slot of digit 3: digit 3 keeps its glyph, digit 4 takes the new one
    sync_load(32'h00000000, 1'b0, 8'h00);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk_in);
      if (k >= 19 && k <= 22)      chk("midload_d3", 8'hF7, 7'b1000000, 1'b1);
      else if (k == 23 || k == 24) chk("midload_blank", 8'hFF, 7'h7F, 1'b1);
      else if (k >= 25)            chk("midload_d4", 8'hEF, 7'b0001110, 1'b1);
      if (k == 20) begin
        value = 32'hFFFFFFFF;
        load  = 1'b1;
      end
      if (k == 21) load = 1'b0;
    end

    // Reset during the blank after digit 5
    sync_load(32'h01234567, 1'b0, 8'h00);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk_in);
      if (k == 35) chk("pre_rst_blank", 8'hFF, 7'h7F, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk_in);
    chk("mid_blank_rst", 8'hFF, 7'h7F, 1'b1);
    chk_fd("mid_blank_rst_fd", 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (k <= 4) chk("rst_then_d0", 8'hFE, 7'b1000000, 1'b1);
      else        chk("rst_then_blank", 8'hFF, 7'h7F, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk_in cycles each digit is driven (SHOW phase); legal range >=2.
REQ-002 Parameter BLANK_CYC, default 64, clk_in cycles all anodes are off between digits (anti-ghosting); legal range >=1.
REQ-003 clk_in  input  1  sole clock; all logic on posedge clk_in.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 value  input  32  eight hex nibbles to display; nibble i maps to digit i.
REQ-006 load  input  1  when high, value is captured into the shadow register.
REQ-007 dp_mask  input  8  bit i=1 lights the decimal point of digit i.
REQ-008 lz_blank  input  1  enables leading-zero blanking.
REQ-009 an  output  8  anode enables, active-low; an[i] selects digit i.
REQ-010 seg  output  7  cathodes, active-low, {CG,CF,CE,CD,CC,CB,CA}.
REQ-011 dp  output  1  decimal-point cathode, active-low.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each full 8-digit scan.

Function
REQ-013 Shadow register SHALL load value on any cycle with load=1; display SHALL use only the shadow register.
REQ-014 FSM SHALL have two states, SHOW and BLANK; SHOW lasts TICK_DIV cycles, then BLANK lasts BLANK_CYC cycles, then digit index idx increments mod 8 and the FSM returns to SHOW.
REQ-015 Digit slot period SHALL be exactly TICK_DIV+BLANK_CYC cycles; a frame SHALL be 8 slots.
REQ-016 In SHOW, an SHALL be all-ones except an[idx]=0; in BLANK, an=8'hFF, seg=7'h7F, dp=1.
REQ-017 seg SHALL be the standard hex pattern of shadow nibble idx: 0->7'b1000000, 1->7'b1111001, 7->7'b1111000, 8->7'b0000000, A->7'b0001000, F->7'b0001110.
REQ-018 dp SHALL equal ~dp_mask[idx] in SHOW.
REQ-019 With lz_blank=1, digit i (i>=1) SHALL be blanked (an[i] stays 1, seg=7'h7F, dp=1) when shadow nibbles i..7 are all zero; digit 0 SHALL never be blanked.
REQ-020 an, seg, dp SHALL be registered outputs: one cycle latency from FSM state/idx change to output change.
REQ-021 frame_done SHALL pulse for one cycle on the cycle idx wraps 7->0.
REQ-022 A load mid-slot SHALL NOT change the current digit's outputs until the next slot; scan timing SHALL NOT restart on load.
REQ-023 dp_mask and lz_blank SHALL be sampled live each cycle (no shadowing).

Reset
REQ-024 On rst=1 at a clk_in edge: an=8'hFF, seg=7'h7F, dp=1, frame_done=0, idx=0, state=SHOW, all counters 0, shadow=32'h0.
REQ-025 rst asserted in any state, including mid-BLANK or mid-SHOW, SHALL take effect on that edge; rst SHALL have priority over load.
REQ-026 After rst deasserts, the first SHOW slot for digit 0 SHALL last a full TICK_DIV cycles.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16-entry hex-to-segment constant table, the SHOW/BLANK state encoding and the all-off constants (8'hFF, 7'h7F).
REQ-028 One combinational sub-module hex7_decode (4-bit nibble in, 7-bit active-low seg out) SHALL be instantiated; the prescaler, FSM and blanking logic stay in seg7_scan.

Verification (TICK_DIV=4, BLANK_CYC=2)
REQ-029 Hold rst 3 cycles -> an=8'hFF, seg=7'h7F, dp=1, frame_done=0 throughout and one cycle after release.
REQ-030 load 32'h01234567, lz_blank=0, dp_mask=0 -> an=8'hFE with seg=7'b1111000 for 4 cycles, then an=8'hFF for 2, then an=8'hFD with seg for "6"; frame_done pulses every 48 cycles.
REQ-031 load 32'h000000A0, lz_blank=1 -> digit 0 shows 7'b1000000, digit 1 shows 7'b0001000, an stays 8'hFF during slots 2-7.
REQ-032 load 32'h0, lz_blank=1, dp_mask=8'h01 -> only digit 0 lit, seg=7'b1000000, dp=0; other slots fully dark.
REQ-033 load 32'hFFFFFFFF in cycle 2 of digit-3 SHOW while showing 32'h0 -> digit 3 keeps 7'b1000000 through its slot; digit 4 shows 7'b0001110.
REQ-034 rst pulsed during BLANK after digit 5 -> next cycle reset values; digit 0 then shows for 4 full cycles.
